// File: rtl/mips_boot_dump_ctrl.sv
// Boot-and-dump controller: loads a program into IMEM with the core in reset, runs it to a halt
// word or cycle limit, then streams RF, PC and (macro DUMP_DM_EN) DMEM over valid/ready.
module mips_boot_dump_ctrl #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       IMEM_DEPTH = 8192,
  parameter int unsigned       RF_DEPTH   = 32,
  parameter int unsigned       DMEM_DEPTH = 8192,
  parameter int unsigned       RST_CYCLES = 4,
  parameter logic [DATA_W-1:0] HALT_WORD  = {DATA_W{1'b1}},
  parameter int unsigned       MAX_CYCLES = 1000000,
  localparam int unsigned      RfAw       = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1,
  localparam int unsigned      DmAw       = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              load_last_i,
  output logic              imem_wr_o,
  output logic [31:0]       imem_addr_o,
  output logic [DATA_W-1:0] imem_wdata_o,
  output logic              cpu_reset_o,
  output logic              cpu_en_o,
  input  logic [DATA_W-1:0] cpu_inst_i,
  input  logic [31:0]       cpu_pc_i,
  output logic [RfAw-1:0]   rf_addr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic [DmAw-1:0]   dm_addr_o,
  input  logic [DATA_W-1:0] dm_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o,
  output logic              done_o,
  output logic              timeout_o
);

  localparam int unsigned LdW   = $clog2(IMEM_DEPTH) + 1;
  localparam int unsigned HoldW = $clog2(RST_CYCLES) + 1;
  localparam int unsigned CycW  = $clog2(MAX_CYCLES) + 1;
  localparam int unsigned RfW   = RfAw + 1;

  typedef enum logic [2:0] {
    StIdle, StLoad, StHold, StRun, StDumpRf, StDumpPc, StDumpDm, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [LdW-1:0]   ld_cnt_q, ld_cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [CycW-1:0]  cyc_q, cyc_d;
  logic [RfW-1:0]   rf_cnt_q, rf_cnt_d;
  logic [31:0]      pc_q, pc_d;
  logic             timeout_q, timeout_d;

`ifdef DUMP_DM_EN
  localparam int unsigned DmW = DmAw + 1;
  logic [DmW-1:0] dm_cnt_q, dm_cnt_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) dm_cnt_q <= '0;
    else         dm_cnt_q <= dm_cnt_d;
  end

  assign dm_addr_o = dm_cnt_q[DmAw-1:0];
`else
  logic unused_dm_rdata;
  assign unused_dm_rdata = ^dm_rdata_i;
  assign dm_addr_o       = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      ld_cnt_q  <= '0;
      hold_q    <= '0;
      cyc_q     <= '0;
      rf_cnt_q  <= '0;
      pc_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      hold_q    <= hold_d;
      cyc_q     <= cyc_d;
      rf_cnt_q  <= rf_cnt_d;
      pc_q      <= pc_d;
      timeout_q <= timeout_d;
    end
  end

  assign imem_addr_o  = 32'({ld_cnt_q, 2'b00});
  assign imem_wdata_o = load_data_i;
  assign rf_addr_o    = rf_cnt_q[RfAw-1:0];
  assign timeout_o    = timeout_q;

  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    hold_d       = hold_q;
    cyc_d        = cyc_q;
    rf_cnt_d     = rf_cnt_q;
    pc_d         = pc_q;
    timeout_d    = timeout_q;
`ifdef DUMP_DM_EN
    dm_cnt_d     = dm_cnt_q;
`endif
    load_ready_o = 1'b0;
    imem_wr_o    = 1'b0;
    cpu_reset_o  = 1'b0;
    cpu_en_o     = 1'b0;
    dump_valid_o = 1'b0;
    dump_data_o  = '0;
    dump_last_o  = 1'b0;
    done_o       = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        cpu_reset_o = (state_q == StIdle);
        done_o      = (state_q == StDone);
        if (start_i) begin
          state_d   = StLoad;
          ld_cnt_d  = '0;
          timeout_d = 1'b0;
        end
      end
      StLoad: begin
        load_ready_o = 1'b1;
        cpu_reset_o  = 1'b1;
        if (load_valid_i) begin
          imem_wr_o = 1'b1;
          ld_cnt_d  = ld_cnt_q + LdW'(1);
          if (load_last_i || ld_cnt_q == LdW'(IMEM_DEPTH - 1)) begin
            state_d = StHold;
            hold_d  = '0;
          end
        end
      end
      StHold: begin
        cpu_reset_o = 1'b1;
        if (hold_q == HoldW'(RST_CYCLES - 1)) begin
          state_d = StRun;
          cyc_d   = '0;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StRun: begin
        // Gate the enable on the fetched word so the halt instruction never executes.
        cpu_en_o = (cpu_inst_i != HALT_WORD);
        if (cpu_inst_i == HALT_WORD) begin
          pc_d     = cpu_pc_i;
          rf_cnt_d = '0;
          state_d  = StDumpRf;
        end else if (cyc_q == CycW'(MAX_CYCLES - 1)) begin
          pc_d      = cpu_pc_i;
          rf_cnt_d  = '0;
          timeout_d = 1'b1;
          state_d   = StDumpRf;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StDumpRf: begin
        dump_valid_o = 1'b1;
        dump_data_o  = rf_rdata_i;
        if (dump_ready_i) begin
          if (rf_cnt_q == RfW'(RF_DEPTH - 1)) state_d = StDumpPc;
          else                                rf_cnt_d = rf_cnt_q + RfW'(1);
        end
      end
      StDumpPc: begin
        dump_valid_o = 1'b1;
        dump_data_o  = DATA_W'(pc_q);
`ifdef DUMP_DM_EN
        if (dump_ready_i) begin
          dm_cnt_d = '0;
          state_d  = StDumpDm;
        end
`else
        dump_last_o = 1'b1;
        if (dump_ready_i) state_d = StDone;
`endif
      end
`ifdef DUMP_DM_EN
      StDumpDm: begin
        dump_valid_o = 1'b1;
        dump_data_o  = dm_rdata_i;
        dump_last_o  = (dm_cnt_q == DmW'(DMEM_DEPTH - 1));
        if (dump_ready_i) begin
          if (dump_last_o) state_d = StDone;
          else             dm_cnt_d = dm_cnt_q + DmW'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: doc/mips_boot_dump_ctrl.md
# mips_boot_dump_ctrl

Synthesizable boot-and-dump controller for the MIPS_processor. It streams a program image into instruction memory while holding the core in reset, then releases the core and runs it until a halt word or a cycle timeout. It then freezes the core and streams out the register file, the captured PC and the data memory over a valid/ready port. It replaces bench-only load/dump sequencing so the same flow runs on silicon or FPGA.

## Interface
- DATA_W, 32, instruction/data word width
- IMEM_DEPTH, 8192, instruction memory words; load count limit
- RF_DEPTH, 32, register file entries dumped
- DMEM_DEPTH, 8192, data memory words dumped
- RST_CYCLES, 4, cycles cpu_reset is held after load completes (≥1)
- HALT_WORD, 32'hFFFF_FFFF, fetched instruction that ends RUN
- MAX_CYCLES, 1000000, RUN cycle limit before forced stop
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a LOAD session; sampled in IDLE and DONE
- load_valid / load_ready  in / out  1  program stream handshake
- load_data  in  DATA_W  program word
- load_last  in  1  final program word
- imem_wr  out  1  instruction memory write strobe
- imem_addr  out  32  byte address, 4×word index
- imem_wdata  out  DATA_W  write data
- cpu_reset  out  1  core reset
- cpu_en  out  1  core clock enable
- cpu_inst  in  DATA_W  currently fetched instruction
- cpu_pc  in  32  core PC
- rf_addr  out  clog2(RF_DEPTH)  RF read address; asynchronous read port
- rf_rdata  in  DATA_W
- dm_addr  out  clog2(DMEM_DEPTH)  DMEM read address; asynchronous read port
- dm_rdata  in  DATA_W
- dump_valid / dump_ready  out / in  1  dump stream handshake
- dump_data  out  DATA_W  dump word
- dump_last  out  1  final dump word
- done  out  1  session complete
- timeout  out  1  RUN ended by MAX_CYCLES, not by HALT_WORD

## Operation
- States: IDLE → LOAD → HOLD → RUN → DUMP_RF → DUMP_PC → DUMP_DM → DONE.
- IDLE: load_ready=0. start=1 moves to LOAD and clears the word counter and timeout.
- LOAD:
  - load_ready=1.
  - On a handshake: imem_wr=1 combinationally, imem_addr=4×count, imem_wdata=load_data; count increments.
  - load_last, or the IMEM_DEPTH-th word, moves to HOLD.
  - Further words are not accepted (load_ready=0 outside LOAD).
  - Unwritten IMEM locations are untouched.
- HOLD: cpu_reset=1 for RST_CYCLES cycles, then RUN.
- RUN:
  - cpu_reset=0.
  - cpu_en = (cpu_inst != HALT_WORD) combinationally, so the halt word never executes.
  - Halt-word cycle: capture cpu_pc, go to DUMP_RF.
  - Cycle counter reaches MAX_CYCLES: capture cpu_pc, set timeout, go to DUMP_RF.
  - Halt takes priority if both occur in the same cycle; timeout stays 0.
- DUMP states:
  - cpu_en=0.
  - dump_valid=1; dump_data muxes rf_rdata / captured PC / dm_rdata.
  - Addresses advance only on a handshake, so data is stable while valid && !ready.
  - Order: RF[0..RF_DEPTH-1], PC, DMEM[0..DMEM_DEPTH-1].
  - dump_last is asserted with the final word.
- DONE: done=1, cpu_en=0, cpu_reset=0. start=1 returns to LOAD (new session, done cleared).

## Timing
- Reset values: state IDLE, cpu_reset=1, cpu_en=0, load_ready=0, imem_wr=0, imem_addr=0, rf_addr=0, dm_addr=0, dump_valid=0, dump_last=0, done=0, timeout=0, all counters 0.
- Load throughput: one word per cycle while load_valid=1.
- LOAD→RUN: the last load handshake is followed by exactly RST_CYCLES cycles of cpu_reset=1.
- Halt to first dump_valid: 1 cycle.
- Dump throughput: one word per cycle with dump_ready held high. Total words = RF_DEPTH+1+DMEM_DEPTH.
- Counters are clog2(depth)+1 bits. No wrap: terminal counts trigger state transitions.
- reset in any state aborts in the same edge: dump/load stop mid-stream, no dump_last is issued, and the core is held in reset.

## Configuration
- DUMP_DM_EN defined: DUMP_DM is included as described.
- DUMP_DM_EN undefined:
  - DUMP_PC goes directly to DONE.
  - The PC word carries dump_last.
  - dm_addr is tied to 0.
  - Total words = RF_DEPTH+1.

## Test plan
- Load 3 words (last on 3rd), RST_CYCLES=4 -> imem_wr at 0x0/0x4/0x8, cpu_reset high 4 cycles, then cpu_en=1.
- Program halts at PC 0x8 with RF_DEPTH=4, DMEM_DEPTH=4, dump_ready=1 -> 9 consecutive words; word 5 = 0x00000008; dump_last on word 9; done=1; timeout=0.
- Random dump_ready stalls -> dump_data stable while stalled; same 9-word sequence; no duplicates or drops.
- Program never halts, MAX_CYCLES=100 -> RUN ends after 100 cycles, timeout=1, dump proceeds.
- IMEM_DEPTH=4, 6 words offered with no load_last -> 4 writes (0x0–0xC), load_ready drops, words 5–6 not accepted.
- reset asserted mid-DUMP_DM -> next cycle IDLE, dump_valid=0, cpu_reset=1; then start re-runs a full session correctly. Without DUMP_DM_EN -> dump_last on the PC word.
